// File: rtl/hilo_div_seq_pkg.sv
// Shared definitions for the HI/LO divide unit: FSM state encoding,
// default operand width and the iteration-counter width helper.
package hilo_div_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/hilo_div_seq_div_restore_step.sv
// One restoring-division step: shift the next quotient bit into the
// partial remainder, then subtract the divisor if it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // The shifted remainder needs one extra bit so divisors >= 2^(W-1) compare correctly.
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  assign shifted_s = {rem_in, quo_in[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, divisor};

  always_comb begin
    rem_out = shifted_s[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (shifted_s >= {1'b0, divisor}) begin
      rem_out    = diff_s[WIDTH-1:0];
      quo_out[0] = 1'b1;
    end else begin
      quo_out[0] = 1'b0;
    end
  end

endmodule

// File: rtl/hilo_div_seq.sv
// Multi-cycle DIV/DIVU unit owning the HI/LO registers: one restoring step
// per cycle, sign fixup on the way out, plus idle-time MTHI/MTLO writes.
module hilo_div_seq
  import hilo_div_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dbz_flag_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] dividend_abs_d;
  logic [WIDTH-1:0] divisor_abs_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_fix_d;
  logic [WIDTH-1:0] quo_fix_d;

  // Magnitudes are plain W-bit unsigned, so -2^(W-1) maps onto itself correctly.
  always_comb begin
    dividend_abs_d = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs_d  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    quo_fix_d      = neg_quo_q ? -quo_q : quo_q;
    rem_fix_d      = neg_rem_q ? -rem_q : rem_q;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_d),
    .quo_out (quo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quo_q      <= {WIDTH{1'b0}};
      dvs_q      <= {WIDTH{1'b0}};
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            busy_q    <= 1'b1;
            neg_quo_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= is_signed & dividend[WIDTH-1];
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= dividend_abs_d;
            dvs_q     <= divisor_abs_d;
            cnt_q     <= CW'(WIDTH - 1);
            if (divisor == {WIDTH{1'b0}}) begin
              dbz_flag_q <= 1'b1;
              state_q    <= ST_FINISH;
            end else begin
              dbz_flag_q <= 1'b0;
              state_q    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == {CW{1'b0}}) begin
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_FINISH: begin
          // A zero divisor leaves HI/LO untouched; only the flags report it.
          if (!dbz_flag_q) begin
            hi_q <= rem_fix_d;
            lo_q <= quo_fix_d;
          end
          done_q  <= 1'b1;
          dbz_q   <= dbz_flag_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_div_seq.sv
// Directed self-checking bench for hilo_div_seq with hand-computed results.
module tb_hilo_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int asserts = 0;
  int fails = 0;

  hilo_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and waits (bounded) for done; reports edges taken.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic stable);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    is_signed = sg; dividend = a; divisor = b; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0; stable = 1'b1;
    while (!done && cycles < 100) begin
      tick();
      cycles++;
      if (!done && (hi !== h0 || lo !== l0)) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    asserts++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    asserts++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    asserts++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    asserts++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_divu();
    int n; logic st;
    is_signed = 1'b0; dividend = 32'd34; divisor = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL divu_busy_rise got %b want 1", busy); end
    n = 0; st = 1'b1;
    while (!done && n < 100) begin
      tick(); n++;
      if (!done && (hi !== 32'h0 || lo !== 32'h0)) st = 1'b0;
    end
    asserts++; if (n !== 33) begin fails++; $display("FAIL divu_latency got %0d want 33", n); end
    asserts++; if (st !== 1'b1) begin fails++; $display("FAIL divu_hilo_stable got %b want 1", st); end
    asserts++; if (hi !== 32'd4) begin fails++; $display("FAIL divu_hi got %h want 4", hi); end
    asserts++; if (lo !== 32'd6) begin fails++; $display("FAIL divu_lo got %h want 6", lo); end
    asserts++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL divu_dbz got %b want 0", div_by_zero); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL divu_busy_at_done got %b want 0", busy); end
    tick();
    asserts++; if (done !== 1'b0) begin fails++; $display("FAIL divu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_signed();
    int n; logic st;
    run_div(1'b1, 32'hFFFF_FFDE, 32'd5, n, st);
    asserts++; if (hi !== 32'hFFFF_FFFC) begin fails++; $display("FAIL div_neg34_5_hi got %h want fffffffc", hi); end
    asserts++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL div_neg34_5_lo got %h want fffffffa", lo); end
    run_div(1'b1, 32'd34, 32'hFFFF_FFFB, n, st);
    asserts++; if (hi !== 32'd4) begin fails++; $display("FAIL div_34_neg5_hi got %h want 4", hi); end
    asserts++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL div_34_neg5_lo got %h want fffffffa", lo); end
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n, st);
    asserts++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    asserts++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi got %h want 0", hi); end
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, n, st);
    asserts++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_max_1_lo got %h want ffffffff", lo); end
    asserts++; if (hi !== 32'h0) begin fails++; $display("FAIL divu_max_1_hi got %h want 0", hi); end
    run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, n, st);
    asserts++; if (lo !== 32'd1) begin fails++; $display("FAIL divu_bigdiv_lo got %h want 1", lo); end
    asserts++; if (hi !== 32'h7FFF_FFFF) begin fails++; $display("FAIL divu_bigdiv_hi got %h want 7fffffff", hi); end
    run_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, n, st);
    asserts++; if (lo !== 32'h0) begin fails++; $display("FAIL divu_near_lo got %h want 0", lo); end
    asserts++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL divu_near_hi got %h want fffffffe", hi); end
  endtask

  task automatic test_mt_and_zero();
    int n; logic st;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1234;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    asserts++; if (hi !== 32'h1234) begin fails++; $display("FAIL mt_both_hi got %h want 1234", hi); end
    asserts++; if (lo !== 32'h1234) begin fails++; $display("FAIL mt_both_lo got %h want 1234", lo); end
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    mthi = 1'b0;
    asserts++; if (hi !== 32'hAAAA) begin fails++; $display("FAIL mthi_hi got %h want aaaa", hi); end
    asserts++; if (lo !== 32'h1234) begin fails++; $display("FAIL mthi_lo_kept got %h want 1234", lo); end
    run_div(1'b0, 32'd77, 32'd0, n, st);
    asserts++; if (n !== 1) begin fails++; $display("FAIL dbz_latency got %0d want 1", n); end
    asserts++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    asserts++; if (hi !== 32'hAAAA) begin fails++; $display("FAIL dbz_hi_kept got %h want aaaa", hi); end
    asserts++; if (lo !== 32'h1234) begin fails++; $display("FAIL dbz_lo_kept got %h want 1234", lo); end
    tick();
    asserts++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_pulse got %b want 0", div_by_zero); end
  endtask

  task automatic test_busy_ignore();
    int n; logic [31:0] h0;
    h0 = hi;
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; n = 0;
    for (int i = 0; i < 4; i++) begin tick(); n++; end
    start = 1'b1; dividend = 32'd9; divisor = 32'd3; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    tick(); n++;
    start = 1'b0; mthi = 1'b0;
    asserts++; if (hi !== h0) begin fails++; $display("FAIL busy_mthi_ignored got %h want %h", hi, h0); end
    while (!done && n < 100) begin tick(); n++; end
    asserts++; if (n !== 33) begin fails++; $display("FAIL busy_latency got %0d want 33", n); end
    asserts++; if (hi !== 32'd2) begin fails++; $display("FAIL busy_hi got %h want 2", hi); end
    asserts++; if (lo !== 32'd14) begin fails++; $display("FAIL busy_lo got %h want e", lo); end
    tick();
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_no_requeue got %b want 0", busy); end
  endtask

  task automatic test_mt_with_start();
    int n; logic st;
    mtlo = 1'b1; wdata = 32'h0000_0077;
    is_signed = 1'b0; dividend = 32'd34; divisor = 32'd5; start = 1'b1;
    tick();
    mtlo = 1'b0; start = 1'b0;
    asserts++; if (lo !== 32'h77) begin fails++; $display("FAIL mt_start_lo_written got %h want 77", lo); end
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    asserts++; if (lo !== 32'd6) begin fails++; $display("FAIL mt_start_lo_final got %h want 6", lo); end
    asserts++; if (hi !== 32'd4) begin fails++; $display("FAIL mt_start_hi_final got %h want 4", hi); end
  endtask

  task automatic test_reset_mid();
    int n; logic st; logic saw_done;
    is_signed = 1'b0; dividend = 32'd34; divisor = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    asserts++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi got %h want 0", hi); end
    asserts++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo got %h want 0", lo); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) saw_done = 1'b1; end
    asserts++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rstmid_no_done got %b want 0", saw_done); end
    run_div(1'b0, 32'd34, 32'd5, n, st);
    asserts++; if (n !== 33) begin fails++; $display("FAIL rstmid_rerun_latency got %0d want 33", n); end
    asserts++; if (hi !== 32'd4) begin fails++; $display("FAIL rstmid_rerun_hi got %h want 4", hi); end
    asserts++; if (lo !== 32'd6) begin fails++; $display("FAIL rstmid_rerun_lo got %h want 6", lo); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_mt_and_zero();
    test_busy_ignore();
    test_mt_with_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
